gray_ctr_ud: RTL

Parametrised up/down Gray-code counter with enable, synchronous parallel load, and wrap or saturate mode. Gray and binary views are registered together, with no lag between them. Provides a registered overflow pulse. Used as a pointer and sequence source for CDC-safe FIFO pointers and position counters, where only one bit may change per step.

---
 rtl/gray_ctr_ud.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gray_ctr_ud.sv
// gray_ctr_ud: parametrised up/down Gray-code counter.
// Binary and Gray views are registered on the same edge, so there is no lag between them.
// The counter supports enable, synchronous parallel load, and either wrap or saturate at the limits.
// ovf is a registered one-cycle pulse raised for every limit hit.
// Optional build macro GRAY_CTR_ERR_CHK_EN adds a sticky on-line checker on the err port.
// The checker flags any Gray step that changes more than one bit.
module gray_ctr_ud #(
    parameter int          N    = 4,
    parameter bit          WRAP = 1'b1,
    parameter int unsigned INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         ovf
`ifdef GRAY_CTR_ERR_CHK_EN
    ,
    output logic         err
`endif
);

    localparam logic [N-1:0] INIT_BIN = INIT[N-1:0];
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MAX_BIN  = {N{1'b1}};

    // Binary to reflected Gray code.
    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Next binary count plus limit-hit flag in the MSB.
    // A limit hit either wraps (modulo 2**N) or saturates (holds).
    function automatic logic [N:0] step_next(input logic [N-1:0] b, input logic dir_up);
        logic [N-1:0] nxt;
        logic         hit;
        hit = 1'b0;
        nxt = b;
        if (dir_up) begin
            if (b == MAX_BIN) begin
                hit = 1'b1;
                nxt = WRAP ? '0 : b;
            end else begin
                nxt = b + ONE;
            end
        end else begin
            if (b == '0) begin
                hit = 1'b1;
                nxt = WRAP ? MAX_BIN : b;
            end else begin
                nxt = b - ONE;
            end
        end
        return {hit, nxt};
    endfunction

    logic [N-1:0] r_bin;
    logic [N-1:0] r_gray;
    logic         r_ovf;
    logic [N:0]   w_step;

    assign w_step = step_next(r_bin, up);

    // Count register: reset, then load, then enabled step, then hold; both views move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= INIT_BIN;
            r_gray <= bin2gray(INIT_BIN);
            r_ovf  <= 1'b0;
        end else if (load) begin
            r_bin  <= load_val;
            r_gray <= bin2gray(load_val);
            r_ovf  <= 1'b0;
        end else if (en) begin
            r_bin  <= w_step[N-1:0];
            r_gray <= bin2gray(w_step[N-1:0]);
            r_ovf  <= w_step[N];
        end else begin
            r_ovf  <= 1'b0;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign ovf      = r_ovf;

`ifdef GRAY_CTR_ERR_CHK_EN
    // True when more than one bit of d is set (popcount > 1).
    function automatic logic multi_bit(input logic [N-1:0] d);
        return (d & (d - ONE)) != '0;
    endfunction

    logic [N-1:0] r_prev_gray;
    logic         r_chk_vld;
    logic         r_err;

    // Snapshot of the Gray value as it was before the latest edge; pure data, no reset needed.
    always_ff @(posedge clk) begin
        r_prev_gray <= r_gray;
    end

    // A load edge is not a step, so it leaves the pair unchecked; any multi-bit step latches err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_vld <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_chk_vld <= ~load;
            if (r_chk_vld && multi_bit(r_gray ^ r_prev_gray)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule
